// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver. Oversamples sclk/lrclk/sdata on clk, assembles
// MSB-first words per slot and publishes each complete left/right pair with
// a one-cycle valid strobe.
// Build option: define I2S_RX_LEFT_JUSTIFIED_EN for left-justified framing
// (boundary bit is the MSB of the new slot); the default is standard I2S
// one-bit-delay framing (boundary bit is the LSB of the completed slot).
module i2s_rx #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             lrclk,
    input  logic             sdata,
    output logic [WIDTH-1:0] left_chan,
    output logic [WIDTH-1:0] right_chan,
    output logic             valid,
    output logic             locked,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // pin index: 0 = sclk, 1 = lrclk, 2 = sdata
    logic [2:0]       pins;
    logic [2:0]       sync1_reg;
    logic [2:0]       sync2_reg;
    logic             sclk_d_reg;
    logic             bit_evt;

    logic             evt_reg;
    logic             lr_cur_reg;
    logic             d_cur_reg;
    logic             lr_prev_reg;
    logic             cur_vld_reg;
    logic             prev_vld_reg;
    logic             boundary;

    logic [WIDTH-1:0] shreg_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] shift_in;
    logic [WIDTH-1:0] shift_sh;
    logic [CNT_W-1:0] cnt_inc;
    logic [WIDTH-1:0] close_sh;
    logic [CNT_W-1:0] close_n;
    logic [WIDTH-1:0] start_sh;
    logic [CNT_W-1:0] start_cnt;
    logic [WIDTH-1:0] word;
    logic             short_slot;

    state_t           state_reg;
    state_t           state_next;
    logic             stage_load;
    logic             publish;
    logic             err_next;
    logic [WIDTH-1:0] stage_reg;
    logic             stage_vld_reg;
    logic [WIDTH-1:0] left_reg;
    logic [WIDTH-1:0] right_reg;
    logic             valid_reg;
    logic             locked_reg;
    logic             err_reg;

    assign pins = {sdata, lrclk, sclk};

    // Two-flop synchronizer on each asynchronous pin
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_reg[gi] <= 1'b0;
                sync2_reg[gi] <= 1'b0;
            end else begin
                sync1_reg[gi] <= pins[gi];
                sync2_reg[gi] <= sync1_reg[gi];
            end
        end
    end

    // Delayed synced sclk for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) sclk_d_reg <= 1'b0;
        else     sclk_d_reg <= sync2_reg[0];
    end

    assign bit_evt = sync2_reg[0] & ~sclk_d_reg;

    // Capture lrclk/sdata on each bit event; lr_prev is only trusted once two
    // events have been seen since reset, so reset itself never fakes a boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_reg      <= 1'b0;
            lr_cur_reg   <= 1'b0;
            d_cur_reg    <= 1'b0;
            lr_prev_reg  <= 1'b0;
            cur_vld_reg  <= 1'b0;
            prev_vld_reg <= 1'b0;
        end else begin
            evt_reg <= bit_evt;
            if (bit_evt) begin
                lr_cur_reg   <= sync2_reg[1];
                d_cur_reg    <= sync2_reg[2];
                lr_prev_reg  <= lr_cur_reg;
                prev_vld_reg <= cur_vld_reg;
                cur_vld_reg  <= 1'b1;
            end
        end
    end

    assign boundary = evt_reg && prev_vld_reg && (lr_cur_reg != lr_prev_reg);

    if (WIDTH == 1) begin : g_sh1
        assign shift_in = d_cur_reg;
    end else begin : g_shn
        assign shift_in = {shreg_reg[WIDTH-2:0], d_cur_reg};
    end

    // Slot datapath: shift/count, and the word produced when a slot closes
    always_comb begin
        shift_sh = (cnt_reg < WIDTH_C) ? shift_in : shreg_reg;
        cnt_inc  = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
        // boundary bit opens the new slot as its MSB
        close_sh  = shreg_reg;
        close_n   = cnt_reg;
        start_sh  = WIDTH'(d_cur_reg);
        start_cnt = CNT_W'(1);
`else
        // boundary bit is the LSB of the slot being closed
        close_sh  = shift_sh;
        close_n   = cnt_inc;
        start_sh  = '0;
        start_cnt = '0;
`endif
        short_slot = (close_n < WIDTH_C);
        word       = short_slot ? (close_sh << (WIDTH_C - close_n)) : close_sh;
    end

    // Shift register and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_reg <= '0;
            cnt_reg   <= '0;
        end else if (evt_reg) begin
            if (boundary) begin
                shreg_reg <= start_sh;
                cnt_reg   <= start_cnt;
            end else begin
                shreg_reg <= shift_sh;
                cnt_reg   <= cnt_inc;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // FSM next state: slots alternate once aligned to the first boundary
    always_comb begin
        state_next = state_reg;
        if (boundary) begin
            case (state_reg)
                IDLE:    state_next = lr_cur_reg ? RIGHT : LEFT;
                LEFT:    state_next = RIGHT;
                RIGHT:   state_next = LEFT;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs: a pair is published only if a left word was staged after
    // alignment, so a lone right slot never produces a mismatched pair
    always_comb begin
        stage_load = 1'b0;
        publish    = 1'b0;
        err_next   = 1'b0;
        if (boundary) begin
            case (state_reg)
                LEFT: begin
                    stage_load = 1'b1;
                    err_next   = short_slot;
                end
                RIGHT: begin
                    publish  = stage_vld_reg;
                    err_next = short_slot;
                end
                default: ;
            endcase
        end
    end

    // Left staging and coherent output pair registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_reg     <= '0;
            stage_vld_reg <= 1'b0;
            left_reg      <= '0;
            right_reg     <= '0;
            valid_reg     <= 1'b0;
            locked_reg    <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            valid_reg <= publish;
            err_reg   <= err_next;
            if (stage_load) begin
                stage_reg     <= word;
                stage_vld_reg <= 1'b1;
            end
            if (publish) begin
                left_reg      <= stage_reg;
                right_reg     <= word;
                locked_reg    <= 1'b1;
                stage_vld_reg <= 1'b0;
            end
        end
    end

    assign left_chan  = left_reg;
    assign right_chan = right_reg;
    assign valid      = valid_reg;
    assign locked     = locked_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed-vector bench for i2s_rx (WIDTH=16, sclk = clk/8).
module tb_i2s_rx;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             sclk;
    logic             lrclk;
    logic             sdata;
    logic [WIDTH-1:0] left_chan;
    logic [WIDTH-1:0] right_chan;
    logic             valid;
    logic             locked;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int v0;
    int e0;

    i2s_rx #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .left_chan  (left_chan),
        .right_chan (right_chan),
        .valid      (valid),
        .locked     (locked),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Observe strobes away from the active edge; one line per published pair
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            $display("pair #%0d: left=%h right=%h", valid_cnt, left_chan, right_chan);
        end
        if (err) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One sclk period of 8 clk: data and lrclk change while sclk is low
    task automatic send_bit(input logic lr, input logic d);
        @(negedge clk);
        sclk  = 1'b0;
        lrclk = lr;
        sdata = d;
        repeat (3) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Standard I2S frame: LSB of each word rides on the opposite lrclk level
    task automatic send_i2s(input int n, input logic [31:0] l, input logic [31:0] r);
        for (int i = n - 1; i >= 0; i--) send_bit((i == 0), l[i]);
        for (int i = n - 1; i >= 0; i--) send_bit((i != 0), r[i]);
    endtask

    // Left-justified 16-bit frame: lrclk changes together with the MSB
    task automatic send_lj(input logic [15:0] l, input logic [15:0] r);
        for (int i = 15; i >= 0; i--) send_bit(1'b0, l[i]);
        for (int i = 15; i >= 0; i--) send_bit(1'b1, r[i]);
    endtask

    // Tail of a previous right slot, ending on its LSB (I2S framing)
    task automatic lead_in();
        repeat (3) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        sclk  = 1'b0;
        lrclk = 1'b0;
        sdata = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_left",   32'(left_chan),  32'h0);
        check("rst_right",  32'(right_chan), 32'h0);
        check("rst_valid",  32'(valid),      32'h0);
        check("rst_locked", 32'(locked),     32'h0);
        check("rst_err",    32'(err),        32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

`ifndef I2S_RX_LEFT_JUSTIFIED_EN
        // Basic 16-bit frames
        lead_in();
        check("t1_unlocked", 32'(locked), 32'h0);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_i2s(16, 32'hA55A, 32'h1234);
        settle();
        check("t1_valid1", 32'(valid_cnt - v0), 32'd1);
        check("t1_left",   32'(left_chan),      32'hA55A);
        check("t1_right",  32'(right_chan),     32'h1234);
        check("t1_locked", 32'(locked),         32'h1);
        send_i2s(16, 32'hA55A, 32'h1234);
        settle();
        check("t1_valid2", 32'(valid_cnt - v0), 32'd2);
        check("t1_err",    32'(err_cnt - e0),   32'd0);
        // sclk stopped: outputs hold, no new pair
        repeat (100) @(negedge clk);
        check("stop_valid",  32'(valid_cnt - v0), 32'd2);
        check("stop_locked", 32'(locked),         32'h1);
        check("stop_left",   32'(left_chan),      32'hA55A);

        // Start mid-right-slot after reset: partial slot discarded
        do_reset();
        check("t2_rst_left",   32'(left_chan),  32'h0);
        check("t2_rst_right",  32'(right_chan), 32'h0);
        check("t2_rst_locked", 32'(locked),     32'h0);
        v0 = valid_cnt;
        e0 = err_cnt;
        repeat (5) send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_i2s(16, 32'h0F0F, 32'hF0F0);
        settle();
        check("t2_valid", 32'(valid_cnt - v0), 32'd1);
        check("t2_left",  32'(left_chan),      32'h0F0F);
        check("t2_right", 32'(right_chan),     32'hF0F0);
        check("t2_err",   32'(err_cnt - e0),   32'd0);

        // 24-bit slots: extra LSBs truncated
        v0 = valid_cnt;
        e0 = err_cnt;
        send_i2s(24, 32'hABCDEF, 32'h123456);
        settle();
        check("t3_valid", 32'(valid_cnt - v0), 32'd1);
        check("t3_left",  32'(left_chan),      32'hABCD);
        check("t3_right", 32'(right_chan),     32'h1234);
        check("t3_err",   32'(err_cnt - e0),   32'd0);

        // 12-bit slots: left-aligned, err per short slot
        v0 = valid_cnt;
        e0 = err_cnt;
        send_i2s(12, 32'hFFF, 32'h123);
        settle();
        check("t4_valid", 32'(valid_cnt - v0), 32'd1);
        check("t4_left",  32'(left_chan),      32'hFFF0);
        check("t4_right", 32'(right_chan),     32'h1230);
        check("t4_err",   32'(err_cnt - e0),   32'd2);

        // Reset mid-left-slot
        for (int i = 15; i >= 8; i--) send_bit(1'b0, 1'b1);
        do_reset();
        check("t5_rst_left",   32'(left_chan),  32'h0);
        check("t5_rst_right",  32'(right_chan), 32'h0);
        check("t5_rst_locked", 32'(locked),     32'h0);
        check("t5_rst_valid",  32'(valid),      32'h0);
        v0 = valid_cnt;
        e0 = err_cnt;
        for (int i = 7; i >= 1; i--) send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        for (int i = 15; i >= 1; i--) send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        settle();
        check("t5_no_valid", 32'(valid_cnt - v0), 32'd0);
        send_i2s(16, 32'h5A5A, 32'hC3C3);
        settle();
        check("t5_valid",  32'(valid_cnt - v0), 32'd1);
        check("t5_left",   32'(left_chan),      32'h5A5A);
        check("t5_right",  32'(right_chan),     32'hC3C3);
        check("t5_locked", 32'(locked),         32'h1);
        check("t5_err",    32'(err_cnt - e0),   32'd0);
`endif

        // Left-justified stream L=8001, R=7FFE
        do_reset();
        v0 = valid_cnt;
        e0 = err_cnt;
        repeat (3) send_bit(1'b1, 1'b0);
        send_lj(16'h8001, 16'h7FFE);
        send_lj(16'h8001, 16'h7FFE);
        send_bit(1'b0, 1'b1);
        settle();
        check("t6_valid", 32'(valid_cnt - v0), 32'd2);
`ifdef I2S_RX_LEFT_JUSTIFIED_EN
        check("t6_left",  32'(left_chan),  32'h8001);
        check("t6_right", 32'(right_chan), 32'h7FFE);
`else
        check("t6_left",  32'(left_chan),  32'h0002);
        check("t6_right", 32'(right_chan), 32'hFFFD);
`endif
        check("t6_err", 32'(err_cnt - e0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
